// File: rtl/pwm_core.sv
// PWM generator datapath: prescaled period counter with double-buffered period/duty/prescale.
// Shadow registers reload only in IDLE or at a period wrap, so register writes never glitch a period.
module pwm_core #(
  parameter int CNT_WIDTH   = 32,
  parameter int PRESC_WIDTH = 16
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic                   cfg_enable,
  input  logic                   cfg_polarity,
  input  logic [CNT_WIDTH-1:0]   cfg_period,
  input  logic [CNT_WIDTH-1:0]   cfg_duty,
  input  logic [PRESC_WIDTH-1:0] cfg_prescale,
  input  logic                   cfg_update,
  output logic                   pwm_out,
  output logic                   period_tick,
  output logic [CNT_WIDTH-1:0]   count_out,
  output logic                   running
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CNT_WIDTH-1:0]   CNT_ONE   = 1;
  localparam logic [PRESC_WIDTH-1:0] PRESC_ONE = 1;

  state_t                 state, state_nxt;
  logic [CNT_WIDTH-1:0]   shdw_p, shdw_d, cnt, cnt_nxt;
  logic [PRESC_WIDTH-1:0] shdw_ps, pcnt, pcnt_nxt;
  logic                   pending, pending_nxt;
  logic                   pwm_nxt;
  logic                   load;
  logic                   tick, p_zero, last, raw;

  always_comb begin
    tick   = (pcnt == shdw_ps);
    p_zero = (shdw_p == '0);
    last   = tick && !p_zero && (cnt == shdw_p - CNT_ONE);
    raw    = !p_zero && (cnt < shdw_d);
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pcnt_nxt    = pcnt;
    pending_nxt = pending;
    pwm_nxt     = cfg_polarity;
    period_tick = 1'b0;
    load        = 1'b0;
    unique case (state)
      IDLE: begin
        load        = 1'b1;
        cnt_nxt     = '0;
        pcnt_nxt    = '0;
        pending_nxt = 1'b0;
        if (cfg_enable) state_nxt = RUN;
      end
      RUN: begin
        if (!cfg_enable) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          pcnt_nxt  = '0;
        end else begin
          period_tick = last;
          pwm_nxt     = raw ^ cfg_polarity;
          pcnt_nxt    = tick ? '0 : pcnt + PRESC_ONE;
          if (tick) cnt_nxt = (last || p_zero) ? '0 : cnt + CNT_ONE;
          // With P=0 every tick counts as a wrap so a pending update can still land.
          if (tick && (last || p_zero) && (pending || cfg_update)) begin
            load        = 1'b1;
            pending_nxt = 1'b0;
          end else if (cfg_update) begin
            pending_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state is written with non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state   <= IDLE;
      shdw_p  <= '0;
      shdw_d  <= '0;
      shdw_ps <= '0;
      pending <= 1'b0;
      pcnt    <= '0;
      cnt     <= '0;
      pwm_out <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      pcnt    <= pcnt_nxt;
      cnt     <= cnt_nxt;
      pwm_out <= pwm_nxt;
      if (load) begin
        shdw_p  <= cfg_period;
        shdw_d  <= cfg_duty;
        shdw_ps <= cfg_prescale;
      end
    end
  end

  assign count_out = cnt;
  assign running   = (state == RUN);

endmodule
